// File: rtl/uart_csr_echo_sequencer.sv
// uart_csr_echo_sequencer: AXI4-Lite master that drives the UART CSR block as a byte echo engine.
// It programs CONTROL once, then polls STATUS, pops RX_DATA and writes each byte back to TX_DATA.
module uart_csr_echo_sequencer #(
  parameter logic [31:0] CSR_BASE     = 32'h0000_0000,
  parameter logic [31:0] CONTROL_INIT = 32'h0000_0001,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  output logic        busy,
  output logic        error,
  output logic [15:0] echo_count,
  output logic [7:0]  last_byte,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam logic [31:0] OFF_CONTROL = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
  localparam logic [31:0] OFF_TX_DATA = 32'h0000_0008;
  localparam logic [31:0] OFF_RX_DATA = 32'h0000_000C;

  // Timer counts 0..TIMEOUT-1; gap counter counts 0..POLL_GAP-1.
  localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? (POLL_GAP - 1) : 0;

  typedef enum logic [2:0] {
    IDLE, CFG_WR, POLL_RD, GAP, RX_RD, TX_POLL_RD, TX_WR, ERROR
  } state_t;

  state_t          state;
  logic            active;
  logic            aw_done, w_done, ar_done, r_done;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      hold;
  logic [7:0]      rdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_ok, w_ok, rd_fin, is_wr, txn_fin, txn_err, timed_out;
  logic [7:0] rd_byte;
  logic unused_rdata;

  // Handshake decode and transaction completion/failure conditions.
  assign aw_hs     = m_awvalid & m_awready;
  assign w_hs      = m_wvalid & m_wready;
  assign b_hs      = m_bready & m_bvalid;
  assign ar_hs     = m_arvalid & m_arready;
  assign r_hs      = m_rvalid & m_rready;
  assign aw_ok     = aw_done | aw_hs;
  assign w_ok      = w_done | w_hs;
  assign rd_fin    = (ar_done | ar_hs) & (r_done | r_hs);
  assign rd_byte   = r_hs ? m_rdata[7:0] : rdata_q;
  assign is_wr     = (state == CFG_WR) || (state == TX_WR);
  assign txn_fin   = is_wr ? b_hs : rd_fin;
  assign txn_err   = is_wr ? (b_hs && (m_bresp != 2'b00)) : (r_hs && (m_rresp != 2'b00));
  assign timed_out = (timer == TW'(TIMEOUT - 1));
  // Only the low byte of any read carries information used here.
  assign unused_rdata = ^m_rdata[31:8];

  // Sequencer FSM with registered AXI outputs and status.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      active     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      ar_done    <= 1'b0;
      r_done     <= 1'b0;
      timer      <= '0;
      gap_cnt    <= '0;
      hold       <= '0;
      rdata_q    <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
      echo_count <= '0;
      last_byte  <= '0;
      m_awaddr   <= '0;
      m_awvalid  <= 1'b0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      m_araddr   <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
    end else if (active && (txn_err || (timed_out && !txn_fin))) begin
      // Bad response or timeout: abandon the transaction and park in ERROR.
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      active    <= 1'b0;
      error     <= 1'b1;
      busy      <= 1'b0;
      state     <= ERROR;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= CFG_WR;
            busy   <= 1'b1;
            active <= 1'b0;
          end
        end

        CFG_WR, TX_WR: begin
          if (!active) begin
            m_awaddr  <= CSR_BASE + ((state == TX_WR) ? OFF_TX_DATA : OFF_CONTROL);
            m_wdata   <= (state == TX_WR) ? {24'h0, hold} : CONTROL_INIT;
            m_wstrb   <= (state == TX_WR) ? 4'h1 : 4'hF;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            timer     <= '0;
            active    <= 1'b1;
          end else if (b_hs) begin
            m_bready <= 1'b0;
            active   <= 1'b0;
            state    <= POLL_RD;
            if (state == TX_WR) begin
              echo_count <= echo_count + 16'd1;
              last_byte  <= hold;
            end
          end else begin
            timer <= timer + TW'(1);
            if (aw_hs) begin
              m_awvalid <= 1'b0;
              aw_done   <= 1'b1;
            end
            if (w_hs) begin
              m_wvalid <= 1'b0;
              w_done   <= 1'b1;
            end
            if (aw_ok && w_ok) m_bready <= 1'b1;
          end
        end

        POLL_RD, RX_RD, TX_POLL_RD: begin
          if (!active) begin
            m_araddr  <= CSR_BASE + ((state == RX_RD) ? OFF_RX_DATA : OFF_STATUS);
            m_arvalid <= 1'b1;
            m_rready  <= 1'b1;
            ar_done   <= 1'b0;
            r_done    <= 1'b0;
            timer     <= '0;
            active    <= 1'b1;
          end else if (rd_fin) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            active    <= 1'b0;
            case (state)
              POLL_RD: begin
                if (!rd_byte[2]) begin
                  state <= RX_RD;
                end else begin
                  state   <= GAP;
                  gap_cnt <= '0;
                end
              end
              RX_RD: begin
                hold  <= rd_byte;
                state <= TX_POLL_RD;
              end
              default: begin
                // TX FIFO full keeps us here; the cleared active flag relaunches the poll.
                if (!rd_byte[1]) state <= TX_WR;
              end
            endcase
          end else begin
            timer <= timer + TW'(1);
            if (ar_hs) begin
              m_arvalid <= 1'b0;
              ar_done   <= 1'b1;
            end
            if (r_hs) begin
              m_rready <= 1'b0;
              r_done   <= 1'b1;
              rdata_q  <= m_rdata[7:0];
            end
          end
        end

        GAP: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == GW'(GAP_LAST)) begin
            state <= POLL_RD;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        ERROR: begin
          if (!enable) begin
            state <= IDLE;
            error <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_csr_echo_sequencer.sv
// Bench for uart_csr_echo_sequencer: behavioural CSR slave plus an in-order echo reference model.
`timescale 1ns/1ps
module tb_uart_csr_echo_sequencer;

  localparam int unsigned TO = 16;

  logic        aclk = 1'b0;
  logic        areset, enable;
  logic        busy, error;
  logic [15:0] echo_count;
  logic [7:0]  last_byte;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  always #5 aclk = ~aclk;

  uart_csr_echo_sequencer #(
    .CSR_BASE(32'h0000_0000), .CONTROL_INIT(32'h0000_0001), .POLL_GAP(2), .TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .busy(busy), .error(error),
    .echo_count(echo_count), .last_byte(last_byte),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // Slave knobs
  int ar_delay = 0, aw_delay = 0, w_delay = 0;
  bit tx_full = 1'b0, inject_rresp = 1'b0, no_bvalid = 1'b0;

  // Slave state
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  bit          aw_got = 1'b0, w_got = 1'b0, bvalid_q = 1'b0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, b_addr = '0, b_data = '0;
  logic [3:0]  cap_wstrb = '0, b_strb = '0;
  logic [7:0]  rx_mem [64];
  int          rx_rd = 0, rx_wr = 0;

  // Logs and counters
  logic [31:0] wa_log[$], wd_log[$];
  logic [3:0]  ws_log[$];
  logic [7:0]  tx_bytes[$];
  logic [7:0]  exp_bytes[$];
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int status_reads = 0, stab_viol = 0;
  int total = 0, bad = 0;

  assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
  assign m_wready  = m_wvalid && (w_cnt >= w_delay);
  assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
  assign m_rvalid  = m_arvalid && m_arready;
  assign m_bvalid  = bvalid_q;
  assign m_bresp   = 2'b00;

  // Register file read view: STATUS and RX_DATA (upper bits are junk on purpose).
  always_comb begin
    m_rdata = 32'h0;
    m_rresp = 2'b00;
    if (m_araddr == 32'h4) begin
      m_rdata = {28'h0, 1'b0, (rx_rd == rx_wr), tx_full, 1'b1};
    end else if (m_araddr == 32'hC) begin
      m_rdata = {24'hA5A5A5, rx_mem[rx_rd[5:0]]};
      if (inject_rresp) m_rresp = 2'b10;
    end
  end

  // Slave transaction tracking and write logging.
  always @(posedge aclk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b0;
    end else begin
      aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
      if (m_awvalid && m_awready) aw_hs_n <= aw_hs_n + 1;
      if (m_wvalid && m_wready) w_hs_n <= w_hs_n + 1;
      if (!bvalid_q && !no_bvalid && (aw_got || (m_awvalid && m_awready)) &&
          (w_got || (m_wvalid && m_wready))) begin
        bvalid_q <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        b_addr   <= aw_got ? cap_awaddr : m_awaddr;
        b_data   <= w_got ? cap_wdata : m_wdata;
        b_strb   <= w_got ? cap_wstrb : m_wstrb;
      end else begin
        if (m_awvalid && m_awready) begin aw_got <= 1'b1; cap_awaddr <= m_awaddr; end
        if (m_wvalid && m_wready) begin w_got <= 1'b1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
      end
      if (bvalid_q && m_bready) begin
        bvalid_q <= 1'b0;
        b_hs_n   <= b_hs_n + 1;
        wa_log.push_back(b_addr);
        wd_log.push_back(b_data);
        ws_log.push_back(b_strb);
        if (b_addr == 32'h8) tx_bytes.push_back(b_data[7:0]);
      end
      if (m_arvalid && m_arready) ar_hs_n <= ar_hs_n + 1;
      if (m_rvalid && m_rready) begin
        r_hs_n <= r_hs_n + 1;
        if (m_araddr == 32'h4) status_reads <= status_reads + 1;
        if (m_araddr == 32'hC && !inject_rresp && rx_rd != rx_wr) rx_rd <= rx_rd + 1;
      end
    end
  end

  // Valid/payload stability monitor.
  logic p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;
  always @(posedge aclk) begin
    if (!areset && !error) begin
      if (p_aw && (!m_awvalid || m_awaddr !== p_awaddr)) stab_viol <= stab_viol + 1;
      if (p_w && (!m_wvalid || m_wdata !== p_wdata || m_wstrb !== p_wstrb)) stab_viol <= stab_viol + 1;
      if (p_ar && (!m_arvalid || m_araddr !== p_araddr)) stab_viol <= stab_viol + 1;
    end
    p_aw <= m_awvalid && !m_awready; p_awaddr <= m_awaddr;
    p_w  <= m_wvalid && !m_wready;   p_wdata  <= m_wdata; p_wstrb <= m_wstrb;
    p_ar <= m_arvalid && !m_arready; p_araddr <= m_araddr;
  end

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr[5:0]] = b;
    rx_wr = rx_wr + 1;
    exp_bytes.push_back(b);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int k = 0;
    while (tx_bytes.size() < n && k < 3000) begin @(negedge aclk); k++; end
    ok = (tx_bytes.size() >= n);
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_reset();
    int act = 0;
    areset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge aclk);
    total++; if ({busy, error} !== 2'b00) begin bad++; $display("FAIL reset_busy_error: got %b want 00", {busy, error}); end
    total++; if (echo_count !== 16'h0) begin bad++; $display("FAIL reset_echo_count: got %h want 0", echo_count); end
    total++; if (last_byte !== 8'h0) begin bad++; $display("FAIL reset_last_byte: got %h want 0", last_byte); end
    total++; if ({m_awaddr, m_wdata, m_wstrb, m_araddr} !== 100'h0) begin
      bad++; $display("FAIL reset_payload: aw=%h w=%h s=%h ar=%h want 0", m_awaddr, m_wdata, m_wstrb, m_araddr); end
    total++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      bad++; $display("FAIL reset_valids: got %b want 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
    areset = 1'b0;
    repeat (100) begin
      @(negedge aclk);
      if (m_awvalid || m_wvalid || m_bready || m_arvalid || m_rready) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL idle_no_valid: active cycles %0d want 0", act); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_echo();
    int base = tx_bytes.size();
    int wbase = wa_log.size();
    bit ok;
    push_rx(8'h41); push_rx(8'h42);
    enable = 1'b1;
    @(negedge aclk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", busy); end
    wait_tx(base + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_wait: tx count %0d want %0d", tx_bytes.size(), base + 2); end
    total++; if (wa_log[wbase] !== 32'h0 || wd_log[wbase] !== 32'h1 || ws_log[wbase] !== 4'hF) begin
      bad++; $display("FAIL cfg_write: addr %h data %h strb %h want 0/1/f", wa_log[wbase], wd_log[wbase], ws_log[wbase]); end
    total++; if (tx_bytes[base] !== 8'h41) begin bad++; $display("FAIL basic_byte0: got %h want 41", tx_bytes[base]); end
    total++; if (tx_bytes[base + 1] !== 8'h42) begin bad++; $display("FAIL basic_byte1: got %h want 42", tx_bytes[base + 1]); end
    total++; if (echo_count !== 16'd2) begin bad++; $display("FAIL basic_count: got %0d want 2", echo_count); end
    total++; if (last_byte !== 8'h42) begin bad++; $display("FAIL basic_last: got %h want 42", last_byte); end
  endtask

  task automatic test_random_stream();
    int base = tx_bytes.size();
    int wbase = wa_log.size();
    int eb = exp_bytes.size();
    int strb_bad = 0;
    bit ok;
    for (int i = 0; i < 8; i++) push_rx(8'($urandom));
    wait_tx(base + 8, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_wait: tx count %0d want %0d", tx_bytes.size(), base + 8); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (tx_bytes[base + i] !== exp_bytes[eb + i]) begin
        bad++; $display("FAIL rand_byte%0d: got %h want %h", i, tx_bytes[base + i], exp_bytes[eb + i]); end
    end
    for (int i = wbase; i < wa_log.size(); i++)
      if (wa_log[i] != 32'h8 || ws_log[i] != 4'h1 || wd_log[i][31:8] != 24'h0) strb_bad++;
    total++; if (strb_bad !== 0) begin bad++; $display("FAIL rand_tx_format: bad writes %0d want 0", strb_bad); end
    total++; if (echo_count !== 16'(exp_bytes.size())) begin
      bad++; $display("FAIL rand_count: got %0d want %0d", echo_count, exp_bytes.size()); end
    total++; if (last_byte !== exp_bytes[exp_bytes.size() - 1]) begin
      bad++; $display("FAIL rand_last: got %h want %h", last_byte, exp_bytes[exp_bytes.size() - 1]); end
  endtask

  task automatic test_tx_full();
    int base = tx_bytes.size();
    int s0;
    bit ok;
    tx_full = 1'b1;
    push_rx(8'h55);
    s0 = status_reads;
    repeat (50) @(negedge aclk);
    total++; if (tx_bytes.size() !== base) begin bad++; $display("FAIL full_no_write: tx count %0d want %0d", tx_bytes.size(), base); end
    total++; if (status_reads - s0 < 10) begin bad++; $display("FAIL full_polls: got %0d want >=10", status_reads - s0); end
    tx_full = 1'b0;
    wait_tx(base + 1, ok);
    total++; if (!ok || tx_bytes[base] !== 8'h55) begin bad++; $display("FAIL full_byte: got %h want 55", tx_bytes[base]); end
    total++; if (echo_count !== 16'(exp_bytes.size())) begin
      bad++; $display("FAIL full_count: got %0d want %0d", echo_count, exp_bytes.size()); end
  endtask

  task automatic test_slow_slave();
    int base = tx_bytes.size();
    int eb = exp_bytes.size();
    bit ok;
    ar_delay = 3; w_delay = 1; aw_delay = 3;
    push_rx(8'($urandom)); push_rx(8'($urandom));
    wait_tx(base + 2, ok);
    total++; if (!ok || tx_bytes[base] !== exp_bytes[eb] || tx_bytes[base + 1] !== exp_bytes[eb + 1]) begin
      bad++; $display("FAIL slow_bytes: got %h %h want %h %h", tx_bytes[base], tx_bytes[base + 1], exp_bytes[eb], exp_bytes[eb + 1]); end
    total++; if (stab_viol !== 0) begin bad++; $display("FAIL slow_stable: violations %0d want 0", stab_viol); end
    total++; if (aw_hs_n !== w_hs_n || w_hs_n !== b_hs_n) begin
      bad++; $display("FAIL slow_wr_single: aw %0d w %0d b %0d want equal", aw_hs_n, w_hs_n, b_hs_n); end
    total++; if (ar_hs_n !== r_hs_n) begin bad++; $display("FAIL slow_rd_single: ar %0d r %0d want equal", ar_hs_n, r_hs_n); end
    ar_delay = 0; w_delay = 0; aw_delay = 0;
  endtask

  task automatic test_rresp_error();
    int base = tx_bytes.size();
    int eb = exp_bytes.size();
    int k = 0;
    int wl;
    bit ok;
    inject_rresp = 1'b1;
    push_rx(8'($urandom));
    while (error !== 1'b1 && k < 500) begin @(negedge aclk); k++; end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL rresp_error: got %b want 1", error); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rresp_busy: got %b want 0", busy); end
    repeat (3) @(negedge aclk);
    total++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      bad++; $display("FAIL rresp_idle: got %b want 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
    enable = 1'b0; inject_rresp = 1'b0;
    repeat (2) @(negedge aclk);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rresp_clear: got %b want 0", error); end
    wl = wa_log.size();
    enable = 1'b1;
    k = 0;
    while (wa_log.size() <= wl && k < 200) begin @(negedge aclk); k++; end
    total++; if (wa_log[wl] !== 32'h0 || wd_log[wl] !== 32'h1) begin
      bad++; $display("FAIL rresp_restart: addr %h data %h want 0/1", wa_log[wl], wd_log[wl]); end
    wait_tx(base + 1, ok);
    total++; if (!ok || tx_bytes[base] !== exp_bytes[eb]) begin
      bad++; $display("FAIL rresp_echo: got %h want %h", tx_bytes[base], exp_bytes[eb]); end
  endtask

  task automatic test_timeout_and_reset();
    int k = 0;
    int act = 0;
    no_bvalid = 1'b1;
    push_rx(8'($urandom));
    while (error !== 1'b1 && k < 500) begin
      @(negedge aclk); k++;
      if (error !== 1'b1 && (m_awvalid || m_wvalid || m_bready)) act++;
    end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL timeout_error: got %b want 1", error); end
    total++; if (act !== TO) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", act, TO); end
    enable = 1'b0;
    repeat (3) @(negedge aclk);
    total++; if ({busy, error} !== 2'b00) begin bad++; $display("FAIL timeout_clear: got %b want 00", {busy, error}); end
    aw_delay = 10;
    enable = 1'b1;
    k = 0;
    while (m_awvalid !== 1'b1 && k < 50) begin @(negedge aclk); k++; end
    total++; if (m_awvalid !== 1'b1) begin bad++; $display("FAIL midwrite_start: awvalid %b want 1", m_awvalid); end
    areset = 1'b1;
    @(negedge aclk);
    total++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b0) begin
      bad++; $display("FAIL midwrite_abort: got %b want 000", {m_awvalid, m_wvalid, m_bready}); end
    total++; if (echo_count !== 16'h0 || last_byte !== 8'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL midwrite_state: count %h last %h busy %b want 0/0/0", echo_count, last_byte, busy); end
    areset = 1'b0; enable = 1'b0; aw_delay = 0; no_bvalid = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    areset = 1'b1;
    enable = 1'b0;
    test_reset();
    test_basic_echo();
    test_random_stream();
    test_tx_full();
    test_slow_slave();
    test_rresp_error();
    test_timeout_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_csr_echo_sequencer.md
# uart_csr_echo_sequencer

AXI4-Lite master that autonomously drives the UART CSR block as a byte echo engine. When enabled, it programs CONTROL once, then repeatedly polls STATUS. Each byte popped from RX_DATA is written back to TX_DATA once the TX FIFO has room. It sits in place of the host on the CSR's AXI4-Lite slave port and is used for loopback bring-up and link test.

## Interface
Parameters:
- CSR_BASE, 32'h0000_0000, base address of the CSR block; register offsets are CONTROL 0x00, STATUS 0x04, TX_DATA 0x08, RX_DATA 0x0C.
- CONTROL_INIT, 32'h0000_0001, value written to CONTROL with wstrb 4'hF at start.
- POLL_GAP, 4, idle cycles between consecutive STATUS polls (0 allowed).
- TIMEOUT, 1024, maximum cycles any single AXI transaction may take before error.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- busy  out  1  high in any state other than IDLE or ERROR.
- error  out  1  sticky; set on timeout or nonzero bresp/rresp.
- echo_count  out  16  bytes echoed since reset; wraps 16'hFFFF→0.
- last_byte  out  8  most recent byte written to TX_DATA.
- m_awaddr/m_awvalid/m_awready  out/out/in  32/1/1  write address channel.
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  write data channel.
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  write response channel.
- m_araddr/m_arvalid/m_arready  out/out/in  32/1/1  read address channel.
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  read data channel.

STATUS bits: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full.

## Operation
- States: IDLE, CFG_WR, POLL_RD, GAP, RX_RD, TX_POLL_RD, TX_WR, ERROR.
- IDLE: when enable=1, go to CFG_WR. CFG_WR writes CONTROL_INIT to CSR_BASE+0x00, then goes to POLL_RD.
- POLL_RD reads CSR_BASE+0x04.
  - rx_empty=0: go to RX_RD.
  - rx_empty=1: go to GAP.
- GAP counts POLL_GAP cycles, then goes to POLL_RD. If enable=0 on entry or at any cycle in GAP, go to IDLE.
- RX_RD reads CSR_BASE+0x0C. The byte is m_rdata[7:0], captured into an internal hold register. Next state is TX_POLL_RD.
- TX_POLL_RD reads STATUS.
  - tx_full=1: repeat TX_POLL_RD.
  - tx_full=0: go to TX_WR.
- TX_WR writes {24'h0, byte} to CSR_BASE+0x08 with wstrb 4'h1. On a good bresp: echo_count+1, last_byte=byte, then go to POLL_RD.
- enable is ignored from RX_RD through TX_WR. A popped byte is always echoed, or error is raised; it is never silently dropped.
- Write transaction:
  - m_awvalid and m_wvalid assert together.
  - Each deasserts independently on its own ready handshake.
  - m_bready asserts once both handshakes are done and stays high until m_bvalid.
  - Addresses and data are held stable while the corresponding valid is high.
- Read transaction:
  - m_arvalid is held until m_arready.
  - m_rready is high from the first cycle of the transaction.
  - Data is accepted on m_rvalid&&m_rready, including the same cycle as the AR handshake (the slave's rvalid may follow arvalid combinationally). The transaction completes only after both the AR and R handshakes.
- Error handling:
  - bresp≠0 or rresp≠0 sets error and goes to ERROR.
  - A timeout counter resets at the start of each transaction. Reaching TIMEOUT drops all valids/readies, sets error and goes to ERROR.
  - ERROR holds all AXI outputs low. It returns to IDLE only when enable=0; error clears on that transition.
- areset in any state: all outputs go to reset values and state goes to IDLE at the next edge. An in-flight AXI transaction is abandoned.

## Timing
- Reset values: all valid/ready outputs 0, addresses/data 0, m_wstrb 0, busy 0, error 0, echo_count 0, last_byte 0.
- Against a zero-wait slave (always-ready, rvalid=arvalid, bvalid next cycle):
  - Read: 1 cycle.
  - Write: 2 cycles (AW/W, then B).
  - State transitions add 1 cycle each.
- Echo latency with a zero-wait slave is at most 12 cycles, measured from RX not-empty at a STATUS poll to the TX_DATA AW handshake.
- busy rises the cycle after IDLE samples enable=1.
- echo_count and last_byte update the cycle after the TX_WR B handshake.
- Outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset with enable=0 → all outputs at reset values; no AXI valid for 100 cycles.
- enable=1 with zero-wait slave model, RX FIFO holding 0x41,0x42 → first transaction is AW 0x00 with data 0x0000_0001; TX_DATA receives 0x41 then 0x42; echo_count=2; last_byte=0x42.
- TX FIFO full for 50 cycles while RX holds 0x55 → repeated STATUS reads; TX_DATA write only after tx_full=0; nothing is lost.
- Slave delays arready 3 cycles and awready 2 cycles after wready → valids held stable; addresses unchanged; single transfer per transaction.
- Slave returns rresp=2'b10 on the RX_DATA read → error=1, busy=0, AXI outputs idle; enable=0 then 1 → error clears and operation restarts at the CONTROL write.
- Slave never asserts bvalid with TIMEOUT=16 → error at cycle 16 of the transaction; areset mid-write → m_awvalid=0 at the next edge, echo_count=0.
